ahb_img_reader: RTL

//  AHB-Lite master that reads a block of 32-bit words from an AHB image-memory slave.

---
 rtl/ahb_pkg.sv | 17 +
 rtl/img_stream_fifo.sv | 50 +++++
 rtl/ahb_img_reader.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings and reader state type shared by the image reader.
package ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_RUN,
        RD_DRAIN
    } rd_state_t;
endpackage

// File: rtl/img_stream_fifo.sv
// img_stream_fifo: synchronous FIFO with occupancy count; push and pop may share a cycle.
module img_stream_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_e, pop_e;

    assign pop_e  = pop && cnt_q != '0;
    assign push_e = push && (cnt_q != (AW+1)'(DEPTH) || pop_e);

    always_comb begin
        wr_d  = push_e ? wr_q + AW'(1) : wr_q;
        rd_d  = pop_e ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + (AW+1)'(push_e) - (AW+1)'(pop_e);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_e) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign valid = cnt_q != '0;
    assign count = cnt_q;
endmodule

// File: rtl/ahb_img_reader.sv
// ahb_img_reader: AHB-Lite master reading a block of words into a valid/ready stream FIFO.
module ahb_img_reader
    import ahb_pkg::*;
#(
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [LEN_W-1:0] word_count,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [2:0]       HBURST,
    output logic [3:0]       HPROT,
    output logic             HMASTLOCK,
    input  logic             HREADY,
    input  logic [31:0]      HRDATA,
    input  logic             HRESP,
    output logic [31:0]      m_data,
    output logic             m_valid,
    input  logic             m_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rd_state_t        state_q, state_d;
    logic [31:0]      haddr_q, haddr_d;
    logic [1:0]       htrans_q, htrans_d;
    logic [LEN_W-1:0] rem_q, rem_d, rem_nx;
    logic             pend_q, pend_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [CW-1:0]    fifo_count;
    logic             acc, push, err_first, credit_ok;

    assign acc       = HREADY && htrans_q == HTRANS_NONSEQ;
    assign push      = HREADY && pend_q && HRESP == HRESP_OKAY;
    assign err_first = pend_q && !HREADY && HRESP == HRESP_ERROR;
    assign rem_nx    = acc ? rem_q - LEN_W'(1) : rem_q;
    // Words already owed to the FIFO, counting the address accepted on this edge.
    assign credit_ok = int'(fifo_count) + int'(pend_q) + int'(acc) < FIFO_DEPTH;

    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        rem_d    = rem_q;
        pend_d   = HREADY ? acc : pend_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q || (pend_q && HRESP == HRESP_ERROR);
        case (state_q)
            RD_IDLE: begin
                if (start && word_count != '0) begin
                    state_d  = RD_RUN;
                    haddr_d  = base_addr & ~32'h3;
                    rem_d    = word_count;
                    htrans_d = HTRANS_NONSEQ;
                    busy_d   = 1'b1;
                    err_d    = 1'b0;
                end else begin
                    done_d = start;
                end
            end
            RD_RUN: begin
                if (err_first) begin
                    htrans_d = HTRANS_IDLE;
                    state_d  = RD_DRAIN;
                end else if (HREADY) begin
                    haddr_d  = acc ? haddr_q + 32'd4 : haddr_q;
                    rem_d    = rem_nx;
                    htrans_d = (rem_nx != '0 && credit_ok) ? HTRANS_NONSEQ : HTRANS_IDLE;
                    state_d  = rem_nx == '0 ? RD_DRAIN : RD_RUN;
                end
            end
            RD_DRAIN: begin
                htrans_d = HTRANS_IDLE;
                if (!pend_q && fifo_count == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= RD_IDLE;
            haddr_q  <= '0;
            htrans_q <= HTRANS_IDLE;
            rem_q    <= '0;
            pend_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            rem_q    <= rem_d;
            pend_q   <= pend_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    img_stream_fifo #(
        .DEPTH(FIFO_DEPTH),
        .W    (32)
    ) u_fifo (
        .clk  (HCLK),
        .rst_n(HRESETn),
        .push (push),
        .din  (HRDATA),
        .pop  (m_ready),
        .dout (m_data),
        .valid(m_valid),
        .count(fifo_count)
    );

    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = 1'b0;
    assign HSIZE     = HSIZE_WORD;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DATA;
    assign HMASTLOCK = 1'b0;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule
